// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: bit/phase sequencer for an I2C master.
// Splits every SCL bit into four quarters of CLK_DIV system clocks and
// walks a bit counter from 1 to FRAME_LEN. It pulses done at the end of a
// frame and returns to idle.
// Optional feature: define I2C_BIT_TIMER_STRETCH_EN to honour slave clock
// stretching. While SCL should be high (quarter 2) but the line is sensed low,
// the prescaler is held.
module i2c_bit_timer #(
  parameter int CLK_DIV   = 125,
  parameter int FRAME_LEN = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       scl_in,
  output logic       ready,
  output logic [5:0] counter,
  output logic [1:0] scl_phase,
  output logic       scl_out,
  output logic       phase_tick,
  output logic       bit_tick,
  output logic       done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [5:0]    CNT_LAST = 6'(FRAME_LEN);

`ifdef I2C_BIT_TIMER_STRETCH_EN
  typedef enum logic [1:0] {IDLE, RUN, STRETCH} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic          ready_q, ready_d;
  logic          scl_out_q, scl_out_d;
  logic          phase_tick_q, phase_tick_d;
  logic          bit_tick_q, bit_tick_d;
  logic          done_q, done_d;
  logic          stall;

`ifndef I2C_BIT_TIMER_STRETCH_EN
  // Without stretching the sensed SCL line has no influence on timing.
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
`endif

  // Next-state logic: frame acceptance, prescaler/phase/bit stepping, completion and cancel.
  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    ready_d      = ready_q;
    scl_out_d    = scl_out_q;
    phase_tick_d = 1'b0;
    bit_tick_d   = 1'b0;
    done_d       = 1'b0;
    stall        = 1'b0;

    if (state_q == IDLE) begin
      if (start && !abort) begin
        state_d    = RUN;
        pre_d      = '0;
        cnt_d      = 6'd1;
        phase_d    = 2'd0;
        ready_d    = 1'b0;
        scl_out_d  = 1'b0;
        bit_tick_d = 1'b1;
      end
    end else if (abort) begin
      state_d   = IDLE;
      pre_d     = '0;
      cnt_d     = 6'd0;
      phase_d   = 2'd0;
      ready_d   = 1'b1;
      scl_out_d = 1'b1;
    end else begin
`ifdef I2C_BIT_TIMER_STRETCH_EN
      // A slave holding SCL low during the high quarter freezes the bit.
      stall = (phase_q == 2'd2) && !scl_in;
`endif
      if (stall) begin
`ifdef I2C_BIT_TIMER_STRETCH_EN
        state_d   = STRETCH;
`endif
        scl_out_d = 1'b1;
      end else begin
        state_d = RUN;
        if (pre_q == PRE_LAST) begin
          pre_d        = '0;
          phase_d      = phase_q + 2'd1;
          phase_tick_d = 1'b1;
          scl_out_d    = phase_d[1];
          if (phase_q == 2'd3) begin
            if (cnt_q == CNT_LAST) begin
              state_d   = IDLE;
              cnt_d     = 6'd0;
              phase_d   = 2'd0;
              ready_d   = 1'b1;
              scl_out_d = 1'b1;
              done_d    = 1'b1;
            end else begin
              cnt_d      = cnt_q + 6'd1;
              bit_tick_d = 1'b1;
            end
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
    end
  end

  // State and registered outputs; reset forces the idle picture at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      cnt_q        <= 6'd0;
      phase_q      <= 2'd0;
      ready_q      <= 1'b1;
      scl_out_q    <= 1'b1;
      phase_tick_q <= 1'b0;
      bit_tick_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      ready_q      <= ready_d;
      scl_out_q    <= scl_out_d;
      phase_tick_q <= phase_tick_d;
      bit_tick_q   <= bit_tick_d;
      done_q       <= done_d;
    end
  end

  assign ready      = ready_q;
  assign counter    = cnt_q;
  assign scl_phase  = phase_q;
  assign scl_out    = scl_out_q;
  assign phase_tick = phase_tick_q;
  assign bit_tick   = bit_tick_q;
  assign done       = done_q;

endmodule

// File: tb/tb_i2c_bit_timer.sv
// Testbench for i2c_bit_timer: a vector table on a tiny instance, hand-written
// corner sequences, and randomized traffic compared against a frame-time model.
module tb_i2c_bit_timer;

  localparam int DA = 4;
  localparam int LA = 29;
  localparam int DB = 2;
  localparam int LB = 1;
`ifdef I2C_BIT_TIMER_STRETCH_EN
  localparam bit STRETCH_ON = 1'b1;
`else
  localparam bit STRETCH_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  logic startA, abortA, sclInA;
  logic readyA, sclOutA, ptA, btA, doneA;
  logic [5:0] counterA;
  logic [1:0] phaseA;
  logic [12:0] outA;

  logic startB, abortB, sclInB;
  logic readyB, sclOutB, ptB, btB, doneB;
  logic [5:0] counterB;
  logic [1:0] phaseB;
  logic [12:0] outB;

  int total = 0;
  int bad = 0;

  // Behavioural model state: elapsed un-stalled clocks since frame accept.
  bit mActive;
  int mT;
  bit mDone, mPt, mBt;

  typedef struct {
    logic start;
    logic abort;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[21];

  i2c_bit_timer #(.CLK_DIV(DA), .FRAME_LEN(LA)) dutA (
    .clk(clk), .reset(reset), .start(startA), .abort(abortA), .scl_in(sclInA),
    .ready(readyA), .counter(counterA), .scl_phase(phaseA), .scl_out(sclOutA),
    .phase_tick(ptA), .bit_tick(btA), .done(doneA)
  );

  i2c_bit_timer #(.CLK_DIV(DB), .FRAME_LEN(LB)) dutB (
    .clk(clk), .reset(reset), .start(startB), .abort(abortB), .scl_in(sclInB),
    .ready(readyB), .counter(counterB), .scl_phase(phaseB), .scl_out(sclOutB),
    .phase_tick(ptB), .bit_tick(btB), .done(doneB)
  );

  assign outA = {readyA, counterA, phaseA, sclOutA, ptA, btA, doneA};
  assign outB = {readyB, counterB, phaseB, sclOutB, ptB, btB, doneB};

  always #5 clk = ~clk;

  // Global guard so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [12:0] pk(input logic rdy, input logic [5:0] cnt, input logic [1:0] ph,
                                     input logic so, input logic pt, input logic bt, input logic dn);
    return {rdy, cnt, ph, so, pt, bt, dn};
  endfunction

  localparam logic [12:0] IDLE_OUT = {1'b1, 6'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic [12:0] modelOut();
    int c, p;
    if (!mActive) return pk(1'b1, 6'd0, 2'd0, 1'b1, mPt, mBt, mDone);
    c = mT / (4 * DA) + 1;
    p = (mT / DA) % 4;
    return pk(1'b0, 6'(c), 2'(p), (p >= 2), mPt, mBt, mDone);
  endfunction

  task automatic modelReset();
    mActive = 0; mT = 0; mDone = 0; mPt = 0; mBt = 0;
  endtask

  task automatic modelStep(input logic s, input logic a, input logic scl);
    mPt = 0; mBt = 0; mDone = 0;
    if (!mActive) begin
      if (s && !a) begin
        mActive = 1; mT = 0; mBt = 1;
      end
    end else if (a) begin
      mActive = 0;
    end else if (STRETCH_ON && ((mT / DA) % 4 == 2) && !scl) begin
      // frozen
    end else begin
      mT++;
      if (mT == LA * 4 * DA) begin
        mActive = 0; mDone = 1; mPt = 1;
      end else begin
        mPt = (mT % DA == 0);
        mBt = (mT % (4 * DA) == 0);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge: drive instance A, let one rising edge pass, land on the next negedge.
  task automatic applyStimulus(input logic s, input logic a, input logic scl);
    startA = s; abortA = a; sclInA = scl;
    @(posedge clk);
    modelStep(s, a, scl);
    @(negedge clk);
  endtask

  task automatic waitForA(input int cnt, input int ph, input string name);
    bit found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (counterA == 6'(cnt) && phaseA == 2'(ph)) found = 1;
      else applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    int doneAt;
    int doneCount;
    bit cntOk;

    reset = 1'b1;
    startA = 0; abortA = 0; sclInA = 1;
    startB = 0; abortB = 0; sclInB = 1;
    modelReset();

    tbl[0]  = '{1'b0, 1'b0, pk(1, 0, 0, 1, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b1, pk(1, 0, 0, 1, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b0, pk(0, 1, 0, 0, 0, 1, 0)};
    tbl[3]  = '{1'b1, 1'b0, pk(0, 1, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b0, pk(0, 1, 1, 0, 1, 0, 0)};
    tbl[5]  = '{1'b0, 1'b0, pk(0, 1, 1, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b0, pk(0, 1, 2, 1, 1, 0, 0)};
    tbl[7]  = '{1'b0, 1'b0, pk(0, 1, 2, 1, 0, 0, 0)};
    tbl[8]  = '{1'b0, 1'b0, pk(0, 1, 3, 1, 1, 0, 0)};
    tbl[9]  = '{1'b1, 1'b0, pk(0, 1, 3, 1, 0, 0, 0)};
    tbl[10] = '{1'b1, 1'b0, pk(1, 0, 0, 1, 1, 0, 1)};
    tbl[11] = '{1'b1, 1'b0, pk(0, 1, 0, 0, 0, 1, 0)};
    tbl[12] = '{1'b0, 1'b0, pk(0, 1, 0, 0, 0, 0, 0)};
    tbl[13] = '{1'b0, 1'b0, pk(0, 1, 1, 0, 1, 0, 0)};
    tbl[14] = '{1'b0, 1'b0, pk(0, 1, 1, 0, 0, 0, 0)};
    tbl[15] = '{1'b0, 1'b0, pk(0, 1, 2, 1, 1, 0, 0)};
    tbl[16] = '{1'b0, 1'b0, pk(0, 1, 2, 1, 0, 0, 0)};
    tbl[17] = '{1'b0, 1'b0, pk(0, 1, 3, 1, 1, 0, 0)};
    tbl[18] = '{1'b0, 1'b0, pk(0, 1, 3, 1, 0, 0, 0)};
    tbl[19] = '{1'b0, 1'b1, pk(1, 0, 0, 1, 0, 0, 0)};
    tbl[20] = '{1'b0, 1'b0, pk(1, 0, 0, 1, 0, 0, 0)};

    repeat (2) @(negedge clk);
    checkOutput("resetA", 32'(outA), 32'(IDLE_OUT));
    checkOutput("resetB", 32'(outB), 32'(IDLE_OUT));
    reset = 1'b0;

    $display("[TB] vector table on CLK_DIV=%0d FRAME_LEN=%0d", DB, LB);
    for (int i = 0; i < 21; i++) begin
      startB = tbl[i].start;
      abortB = tbl[i].abort;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vecB%0d", i), 32'(outB), 32'(tbl[i].exp));
    end
    startB = 0; abortB = 0;

    $display("[TB] single frame");
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("accept", 32'({counterA, btA, readyA}), 32'({6'd1, 1'b1, 1'b0}));
    doneAt = -1; cntOk = 1;
    for (int i = 1; i <= 600 && doneAt < 0; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (doneA) doneAt = i;
      else if (counterA != 6'(i / 16 + 1)) cntOk = 0;
    end
    checkOutput("frame_len", 32'(doneAt), 32'd464);
    checkOutput("counter_walk", 32'(cntOk), 32'd1);
    checkOutput("done_counter", 32'({counterA, readyA, btA}), 32'({6'd0, 1'b1, 1'b0}));
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("done_width", 32'(doneA), 32'd0);

    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, 1'b0, 1'b1);
    doneAt = -1;
    for (int i = 1; i <= 600 && doneAt < 0; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (doneA) doneAt = i;
    end
    checkOutput("b2b_done", 32'(doneAt), 32'd464);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("b2b_restart", 32'({counterA, btA, readyA, doneA}), 32'({6'd1, 1'b1, 1'b0, 1'b0}));
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("b2b_abort", 32'(outA), 32'(IDLE_OUT));

    $display("[TB] abort mid-frame");
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitForA(10, 2, "reach_c10p2");
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abort_idle", 32'(outA), 32'(IDLE_OUT));
    doneCount = 0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (doneA) doneCount++;
    end
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitForA(20, 0, "reach_c20");
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", 32'(outA), 32'(IDLE_OUT));
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    doneCount = 0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (doneA) doneCount++;
    end
    checkOutput("reset_no_done", 32'(doneCount), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("restart_after_reset", 32'({counterA, btA}), 32'({6'd1, 1'b1}));
    applyStimulus(1'b0, 1'b1, 1'b1);

    $display("[TB] SCL held low during bit 5 high quarter");
    applyStimulus(1'b1, 1'b0, 1'b1);
    doneAt = -1;
    for (int i = 1; i <= 1000 && doneAt < 0; i++) begin
      if (counterA == 6'd5 && phaseA == 2'd2 && ptA) begin
        for (int k = 0; k < 50; k++) begin
          applyStimulus(1'b0, 1'b0, 1'b0);
          i++;
          if (doneA) doneAt = i;
        end
        i--;
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        if (doneA) doneAt = i;
      end
    end
    checkOutput("stretch_len", 32'(doneAt), STRETCH_ON ? 32'd514 : 32'd464);

    $display("[TB] randomized traffic against model");
    resetPulse();
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 399) == 0, $urandom_range(0, 7) != 0);
      checkOutput($sformatf("rand%0d", i), 32'(outA), 32'(modelOut()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
